// File: rtl/zx_key_player.sv
// zx_key_player
// -------------
// Replays a run-time loadable list of keystroke entries onto the ZX Spectrum
// keyboard matrix as active-low row/column patterns. Playback runs in this
// order: an optional start delay, then for each entry a fetch, a press phase
// and a release gap. Modifiers (Caps Shift / Symbol Shift) and a 4x "hold"
// press time are encoded per entry.
//
// Entry format (16 bits):
//   [15] END  [14] CS  [13] SS  [12] HOLD  [11] reserved
//   [10:8] row  [7:0] active-low column mask (low COLS bits used)
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   wr_en     in   sequence memory write strobe (ignored while busy)
//   wr_addr   in   write address (AW bits)
//   wr_data   in   16-bit entry
//   start     in   one-cycle start pulse (ignored while busy)
//   abort     in   stop playback and release all keys (beats start)
//   keys      out  active-low matrix, row r at [COLS*r +: COLS]
//   busy      out  playback in progress
//   done      out  sequence finished normally (level)
//   cur_addr  out  address of the entry being played
//
// Configuration macro:
//   ZX_KEY_PLAYER_LOOP_EN  when defined, the sequence restarts from address 0
//                          (with the start delay) instead of finishing; done
//                          never asserts and busy stays high until abort/reset.

module zx_key_player #(
    parameter int CLK_FREQ       = 27000000,
    parameter int START_DELAY_MS = 3000,
    parameter int PRESS_MS       = 100,
    parameter int RELEASE_MS     = 100,
    parameter int DEPTH          = 1024,
    parameter int ROWS           = 8,
    parameter int COLS           = 5,
    parameter int CS_ROW         = 0,
    parameter int CS_COL         = 0,
    parameter int SS_ROW         = 7,
    parameter int SS_COL         = 1,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [15:0]            wr_data,
    input  logic                   start,
    input  logic                   abort,
    output logic [ROWS*COLS-1:0]   keys,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          cur_addr
);

`ifdef ZX_KEY_PLAYER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    // Phase lengths in clock cycles.
    localparam int TPM     = CLK_FREQ / 1000;
    localparam int D_CYC   = START_DELAY_MS * TPM;
    localparam int P_CYC   = PRESS_MS * TPM;
    localparam int H_CYC   = 4 * P_CYC;
    localparam int R_CYC   = RELEASE_MS * TPM;
    localparam int MAX_A   = (H_CYC > D_CYC) ? H_CYC : D_CYC;
    localparam int MAX_CYC = (MAX_A > R_CYC) ? MAX_A : R_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The timer counts 0..N-1 within a phase; these are the final counts.
    localparam logic [TW-1:0] D_LAST = TW'((D_CYC > 0) ? D_CYC - 1 : 0);
    localparam logic [TW-1:0] P_LAST = TW'(P_CYC - 1);
    localparam logic [TW-1:0] H_LAST = TW'(H_CYC - 1);
    localparam logic [TW-1:0] R_LAST = TW'(R_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_FETCH,
        ST_PRESS,
        ST_RELEASE,
        ST_DONE
    } state_t;

    // With no start delay, a (re)start goes straight to the fetch.
    localparam state_t ST_RESTART = (D_CYC == 0) ? ST_FETCH : ST_DELAY;
    localparam state_t ST_SEQ_END = LOOP_EN ? ST_RESTART : ST_DONE;

    state_t                 state, state_nxt;
    logic [TW-1:0]          timer, timer_nxt;
    logic [AW-1:0]          cur_addr_nxt;
    logic [ROWS*COLS-1:0]   keys_nxt;
    logic                   busy_nxt, done_nxt;
    logic                   hold, hold_nxt;
    logic                   phase_end;
    logic                   last_addr;
    logic                   entry_end;

    logic [15:0]            mem [DEPTH];
    logic [15:0]            rd_data;
    logic                   unused_rd;

    assign last_addr = (cur_addr == AW'(DEPTH - 1));
    assign entry_end = rd_data[15];
    assign unused_rd = ^{rd_data[11], rd_data[7:0]};

    // Builds the active-low matrix for one entry. A row outside the matrix
    // drops the key mask but still lets the modifiers through.
    function automatic logic [ROWS*COLS-1:0] press_pattern(input logic [15:0] entry);
        logic [ROWS*COLS-1:0] pat;
        pat = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (entry[10:8] == 3'(r)) begin
                pat[COLS*r +: COLS] = entry[COLS-1:0];
            end
        end
        if (entry[14]) begin
            pat[COLS*CS_ROW + CS_COL] = 1'b0;
        end
        if (entry[13]) begin
            pat[COLS*SS_ROW + SS_COL] = 1'b0;
        end
        return pat;
    endfunction

    // Sequence memory. The read address is the next-cycle cur_addr so that
    // the registered read already holds the right entry during FETCH, even
    // when cur_addr advances on the edge entering FETCH.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[cur_addr_nxt];
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            cur_addr <= '0;
            keys     <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
            hold     <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            cur_addr <= cur_addr_nxt;
            keys     <= keys_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            hold     <= hold_nxt;
        end
    end

    // End-of-phase detection for the timed states.
    always_comb begin
        phase_end = 1'b0;
        case (state)
            ST_DELAY:   phase_end = (timer == D_LAST);
            ST_PRESS:   phase_end = hold ? (timer == H_LAST) : (timer == P_LAST);
            ST_RELEASE: phase_end = (timer == R_LAST);
            default:    phase_end = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) state_nxt = ST_RESTART;
                end
                ST_DELAY: begin
                    if (phase_end) state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    state_nxt = entry_end ? ST_SEQ_END : ST_PRESS;
                end
                ST_PRESS: begin
                    if (phase_end) state_nxt = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (phase_end) state_nxt = last_addr ? ST_SEQ_END : ST_FETCH;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output / datapath logic. The timer restarts from zero on every state
    // change and only runs inside the timed states.
    always_comb begin
        timer_nxt    = '0;
        cur_addr_nxt = cur_addr;
        keys_nxt     = keys;
        busy_nxt     = busy;
        done_nxt     = done;
        hold_nxt     = hold;

        if ((state_nxt == state) &&
            (state == ST_DELAY || state == ST_PRESS || state == ST_RELEASE)) begin
            timer_nxt = timer + TW'(1);
        end

        if (abort) begin
            keys_nxt = '1;
            busy_nxt = 1'b0;
            done_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cur_addr_nxt = '0;
                        done_nxt     = 1'b0;
                        busy_nxt     = 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (entry_end) begin
                        if (LOOP_EN) begin
                            cur_addr_nxt = '0;
                        end else begin
                            busy_nxt = 1'b0;
                            done_nxt = 1'b1;
                        end
                    end else begin
                        keys_nxt = press_pattern(rd_data);
                        hold_nxt = rd_data[12];
                    end
                end
                ST_PRESS: begin
                    if (phase_end) keys_nxt = '1;
                end
                ST_RELEASE: begin
                    if (phase_end) begin
                        if (!last_addr) begin
                            cur_addr_nxt = cur_addr + AW'(1);
                        end else if (LOOP_EN) begin
                            cur_addr_nxt = '0;
                        end else begin
                            busy_nxt = 1'b0;
                            done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zx_key_player.sv
// tb_zx_key_player
// ----------------
// Self-checking bench for zx_key_player with TPM=1, start delay 2, press 3,
// release 2 and an 8-entry memory. A reference model turns the bench's copy
// of the sequence memory into an expected per-cycle trace of keys, busy,
// done and cur_addr, indexed by the number of edges after the start edge.

module tb_zx_key_player;

    localparam int D     = 2;
    localparam int P     = 3;
    localparam int R     = 2;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int ROWS  = 8;
    localparam int COLS  = 5;
    localparam int NK    = ROWS * COLS;
    localparam int MAXT  = 1000;

`ifdef ZX_KEY_PLAYER_LOOP_EN
    localparam bit LOOP_MODE = 1'b1;
`else
    localparam bit LOOP_MODE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [15:0]     wr_data;
    logic            start;
    logic            abort;
    logic [NK-1:0]   keys;
    logic            busy;
    logic            done;
    logic [AW-1:0]   cur_addr;

    int checks = 0;
    int errors = 0;

    logic [15:0]     model_mem [DEPTH];
    logic [NK-1:0]   exp_keys  [MAXT];
    logic            exp_busy  [MAXT];
    logic            exp_done  [MAXT];
    logic [AW-1:0]   exp_addr  [MAXT];
    int              exp_len;
    int              fetch_idx [$];

    zx_key_player #(
        .CLK_FREQ(1000), .START_DELAY_MS(D), .PRESS_MS(P), .RELEASE_MS(R),
        .DEPTH(DEPTH), .ROWS(ROWS), .COLS(COLS),
        .CS_ROW(0), .CS_COL(0), .SS_ROW(7), .SS_COL(1)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .abort(abort), .keys(keys),
        .busy(busy), .done(done), .cur_addr(cur_addr)
    );

    always #5 clk = ~clk;

    // Key matrix for one entry: a key is pressed if it is in the entry's row
    // with a zero mask bit, or it is a requested modifier.
    function automatic logic [NK-1:0] model_keys(input logic [15:0] e);
        logic [NK-1:0] k;
        int row;
        bit pressed;
        row = int'(e[10:8]);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pressed = (row == r && e[c] == 1'b0) ||
                          (e[14] && r == 0 && c == 0) ||
                          (e[13] && r == 7 && c == 1);
                k[r*COLS + c] = !pressed;
            end
        end
        return k;
    endfunction

    // Expected trace from the timing rules: fetch of the first entry D edges
    // after start, keys for p cycles, release R cycles, next fetch after that.
    function automatic void build_trace();
        int t, addr, p, loops;
        logic [15:0] e;
        fetch_idx.delete();
        for (int i = 0; i < MAXT; i++) begin
            exp_keys[i] = '1;
            exp_busy[i] = 1'b1;
            exp_done[i] = 1'b0;
            exp_addr[i] = '0;
        end
        t = D; addr = 0; loops = 0; exp_len = -1;
        while (t < MAXT - 40) begin
            fetch_idx.push_back(t);
            exp_addr[t] = AW'(addr);
            e = model_mem[addr];
            if (e[15]) begin
                if (LOOP_MODE) begin
                    loops++;
                    if (loops == 3) begin exp_len = t + D + 2; break; end
                    t = t + D + 1;
                    addr = 0;
                    continue;
                end
                for (int i = t + 1; i < MAXT; i++) begin
                    exp_busy[i] = 1'b0; exp_done[i] = 1'b1; exp_addr[i] = AW'(addr);
                end
                exp_len = t + 4;
                break;
            end
            p = e[12] ? 4 * P : P;
            for (int i = 1; i <= p + R; i++) begin
                exp_addr[t + i] = AW'(addr);
                if (i <= p) exp_keys[t + i] = model_keys(e);
            end
            t = t + p + R + 1;
            if (addr == DEPTH - 1) begin
                if (LOOP_MODE) begin
                    loops++;
                    if (loops == 3) begin exp_len = t + D + 1; break; end
                    t = t + D;
                    addr = 0;
                end else begin
                    for (int i = t; i < MAXT; i++) begin
                        exp_busy[i] = 1'b0; exp_done[i] = 1'b1; exp_addr[i] = AW'(addr);
                    end
                    exp_len = t + 3;
                    break;
                end
            end else begin
                addr++;
            end
        end
        if (exp_len < 0) exp_len = t;
    endfunction

    function automatic logic [15:0] rand_entry();
        logic [15:0] e;
        e = 16'($urandom);
        e[15] = 1'b0;
        return e;
    endfunction

    task automatic write_entry(input int addr, input logic [15:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        model_mem[addr] = data;
    endtask

    // After this returns, the next negedge samples the state one edge after start.
    task automatic start_playback();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic stop_playback();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (keys !== {NK{1'b1}}) begin errors++; $display("[TB] FAIL reset_keys: got %h, want all ones", keys); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, want 0", done); end
        checks++;
        if (cur_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0d, want 0", cur_addr); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({keys, busy, done} !== {{NK{1'b1}}, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL idle: keys=%h busy=%b done=%b, want idle", keys, busy, done);
            end
        end
    endtask

    task automatic test_basic();
        write_entry(0, 16'h051E);
        write_entry(1, 16'h8000);
        build_trace();
        for (int run = 0; run < 2; run++) begin
            start_playback();
            for (int t = 0; t < exp_len; t++) begin
                @(negedge clk);
                checks++;
                if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                    errors++;
                    $display("[TB] FAIL basic run%0d t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                             run, t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
                end
            end
            if (LOOP_MODE) stop_playback();
        end
        stop_playback();
    endtask

    task automatic test_modifiers();
        logic [15:0] entries [3];
        entries[0] = 16'h4002;
        entries[1] = 16'h2701;
        entries[2] = 16'h631F;
        for (int n = 0; n < 3; n++) begin
            write_entry(0, entries[n]);
            write_entry(1, 16'h8000);
            build_trace();
            start_playback();
            for (int t = 0; t < exp_len; t++) begin
                @(negedge clk);
                checks++;
                if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                    errors++;
                    $display("[TB] FAIL modifier %h t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                             entries[n], t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
                end
            end
            stop_playback();
        end
    endtask

    task automatic test_hold();
        write_entry(0, 16'h1017);
        write_entry(1, 16'h8000);
        build_trace();
        start_playback();
        for (int t = 0; t < exp_len; t++) begin
            @(negedge clk);
            checks++;
            if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                errors++;
                $display("[TB] FAIL hold t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                         t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
            end
        end
        stop_playback();
    endtask

    task automatic test_abort();
        int k;
        for (int i = 0; i < 3; i++) write_entry(i, rand_entry());
        write_entry(3, 16'h8000);
        build_trace();
        k = fetch_idx[1] + 2;
        start_playback();
        for (int t = 0; t <= k; t++) begin
            @(negedge clk);
            checks++;
            if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                errors++;
                $display("[TB] FAIL abort_pre t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                         t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({keys, busy, done, cur_addr} !== {{NK{1'b1}}, 1'b0, 1'b0, AW'(1)}) begin
            errors++;
            $display("[TB] FAIL abort: keys=%h busy=%b done=%b addr=%0d, want all ones, 0, 0, 1", keys, busy, done, cur_addr);
        end
        start_playback();
        for (int t = 0; t < exp_len; t++) begin
            @(negedge clk);
            checks++;
            if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                errors++;
                $display("[TB] FAIL abort_replay t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                         t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
            end
        end
        stop_playback();
    endtask

    task automatic test_back_to_back();
        write_entry(0, rand_entry());
        write_entry(1, rand_entry());
        write_entry(2, 16'h8000);
        build_trace();
        start_playback();
        for (int t = 0; t < exp_len; t++) begin
            @(negedge clk);
            checks++;
            if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                errors++;
                $display("[TB] FAIL busy_ignore t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                         t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
            end
            wr_en = (t == 0);
            wr_addr = AW'(1);
            wr_data = ~model_mem[1] & 16'h7FFF;
            start = (t == 5);
        end
        wr_en = 1'b0;
        start = 1'b0;
        stop_playback();
    endtask

    task automatic test_reset_mid();
        int k;
        write_entry(0, rand_entry());
        write_entry(1, rand_entry());
        write_entry(2, 16'h8000);
        build_trace();
        k = fetch_idx[2] - 1;
        start_playback();
        for (int t = 0; t <= k; t++) begin
            @(negedge clk);
            checks++;
            if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                errors++;
                $display("[TB] FAIL reset_mid_pre t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                         t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({keys, busy, done, cur_addr} !== {{NK{1'b1}}, 1'b0, 1'b0, AW'(0)}) begin
            errors++;
            $display("[TB] FAIL reset_mid: keys=%h busy=%b done=%b addr=%0d, want all ones, 0, 0, 0", keys, busy, done, cur_addr);
        end
        start_playback();
        for (int t = 0; t < exp_len; t++) begin
            @(negedge clk);
            checks++;
            if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                errors++;
                $display("[TB] FAIL reset_replay t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                         t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
            end
        end
        stop_playback();
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, DEPTH - 2);
            for (int i = 0; i < n; i++) write_entry(i, rand_entry());
            write_entry(n, 16'h8000 | 16'($urandom_range(0, 16'h7FFF)));
            build_trace();
            start_playback();
            for (int t = 0; t < exp_len; t++) begin
                @(negedge clk);
                checks++;
                if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                    errors++;
                    $display("[TB] FAIL random it%0d t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                             it, t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
                end
            end
            stop_playback();
        end
    endtask

    task automatic test_last_addr();
        for (int i = 0; i < DEPTH; i++) write_entry(i, rand_entry());
        build_trace();
        start_playback();
        for (int t = 0; t < exp_len; t++) begin
            @(negedge clk);
            checks++;
            if ({keys, busy, done, cur_addr} !== {exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]}) begin
                errors++;
                $display("[TB] FAIL last_addr t=%0d: keys=%h busy=%b done=%b addr=%0d, want keys=%h busy=%b done=%b addr=%0d",
                         t, keys, busy, done, cur_addr, exp_keys[t], exp_busy[t], exp_done[t], exp_addr[t]);
            end
        end
        stop_playback();
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        abort   = 1'b0;
        test_reset();
        test_basic();
        test_modifiers();
        test_hold();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_last_addr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
